// File: rtl/msfsm_dec_pkg.sv
// Shared types and encodings for the MSFSM output-event decoder.
package msfsm_dec_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Error type field, err_code[1:0]
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_CONFLICT  = 2'd1;
  localparam logic [1:0] ERR_REDUNDANT = 2'd2;
  localparam logic [1:0] ERR_DUP       = 2'd3;

  // Signal ID field, err_code[3:2]
  localparam logic [1:0] SIG_NONE = 2'd0;
  localparam logic [1:0] SIG_X    = 2'd1;
  localparam logic [1:0] SIG_RO   = 2'd2;
  localparam logic [1:0] SIG_AO   = 2'd3;

  function automatic logic [3:0] mk_code(input logic [1:0] sig, input logic [1:0] typ);
    return {sig, typ};
  endfunction

endpackage

// File: rtl/msfsm_level_cell.sv
// One handshake signal: turns rise/fall strobes into a registered level,
// classifies protocol errors and reports accepted rising edges.
module msfsm_level_cell
  import msfsm_dec_pkg::*;
#(
  parameter bit INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       rise_a_i,
  input  logic       rise_b_i,
  input  logic       fall_a_i,
  input  logic       fall_b_i,
  output logic       level_o,
  output logic [1:0] err_type_o,
  output logic       acc_rise_o
);

  logic level_q, level_d;
  logic rise, fall;

  // Error classification (dup > conflict > redundant) and next level.
  // A disabled cell sees no strobes at all, so it reports no errors either.
  always_comb begin
    rise       = rise_a_i | rise_b_i;
    fall       = fall_a_i | fall_b_i;
    err_type_o = ERR_NONE;
    if (enable_i) begin
      if ((rise_a_i & rise_b_i) | (fall_a_i & fall_b_i))
        err_type_o = ERR_DUP;
      else if (rise & fall)
        err_type_o = ERR_CONFLICT;
      else if ((rise & level_q) | (fall & ~level_q))
        err_type_o = ERR_REDUNDANT;
    end
    acc_rise_o = enable_i & rise & (err_type_o == ERR_NONE);
    level_d    = level_q;
    if (enable_i && err_type_o == ERR_NONE) begin
      if (rise)      level_d = 1'b1;
      else if (fall) level_d = 1'b0;
    end
  end

  // Level register; reset discards any strobe of the same cycle.
  always_ff @(posedge clk) begin
    if (reset) level_q <= INIT;
    else       level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/msfsm_event_decoder.sv
// MSFSM output-event decoder: strobes -> registered x/Ro/Ao levels,
// first-error latch with optional halt, and debug handshake counters.
module msfsm_event_decoder
  import msfsm_dec_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          INIT_X      = 1'b0,
  parameter bit          INIT_RO     = 1'b0,
  parameter bit          INIT_AO     = 1'b0,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_PLUS,
  input  logic             x_MINUS,
  input  logic             Ro_PLUS,
  input  logic             Ro_PLUSa,
  input  logic             Ro_MINUS,
  input  logic             Ro_MINUSa,
  input  logic             Ao_PLUS,
  input  logic             Ao_MINUS,
  input  logic             err_clr,
  output logic             x,
  output logic             Ro,
  output logic             Ao,
  output logic             err,
  output logic [3:0]       err_code,
  output logic [CNT_W-1:0] ro_cycles,
  output logic [CNT_W-1:0] ao_cycles
);

  state_e           state_q;
  logic             err_q;
  logic [3:0]       code_q;
  logic [CNT_W-1:0] ro_cnt_q, ao_cnt_q;

  logic       enable;
  logic [1:0] x_et, ro_et, ao_et;
  logic       x_acc, ro_acc, ao_acc;
  logic       new_err;
  logic [3:0] new_code;

  // In HALT every strobe is dropped, including those arriving with err_clr.
  assign enable = (state_q == RUN);

  msfsm_level_cell #(.INIT(INIT_X)) u_x (
    .clk(clk), .reset(reset), .enable_i(enable),
    .rise_a_i(x_PLUS), .rise_b_i(1'b0), .fall_a_i(x_MINUS), .fall_b_i(1'b0),
    .level_o(x), .err_type_o(x_et), .acc_rise_o(x_acc)
  );

  msfsm_level_cell #(.INIT(INIT_RO)) u_ro (
    .clk(clk), .reset(reset), .enable_i(enable),
    .rise_a_i(Ro_PLUS), .rise_b_i(Ro_PLUSa), .fall_a_i(Ro_MINUS), .fall_b_i(Ro_MINUSa),
    .level_o(Ro), .err_type_o(ro_et), .acc_rise_o(ro_acc)
  );

  msfsm_level_cell #(.INIT(INIT_AO)) u_ao (
    .clk(clk), .reset(reset), .enable_i(enable),
    .rise_a_i(Ao_PLUS), .rise_b_i(1'b0), .fall_a_i(Ao_MINUS), .fall_b_i(1'b0),
    .level_o(Ao), .err_type_o(ao_et), .acc_rise_o(ao_acc)
  );

  // Signal priority x > Ro > Ao when several signals err in one cycle.
  always_comb begin
    new_err  = 1'b1;
    new_code = mk_code(SIG_NONE, ERR_NONE);
    if (x_et != ERR_NONE)       new_code = mk_code(SIG_X, x_et);
    else if (ro_et != ERR_NONE) new_code = mk_code(SIG_RO, ro_et);
    else if (ao_et != ERR_NONE) new_code = mk_code(SIG_AO, ao_et);
    else                        new_err  = 1'b0;
  end

  // Controller FSM, sticky first-error latch and wrap-around counters.
  // A fresh error beats a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      err_q    <= 1'b0;
      code_q   <= 4'd0;
      ro_cnt_q <= '0;
      ao_cnt_q <= '0;
    end else begin
      if (ro_acc) ro_cnt_q <= ro_cnt_q + CNT_W'(1);
      if (ao_acc) ao_cnt_q <= ao_cnt_q + CNT_W'(1);

      case (state_q)
        RUN:     if (new_err && STOP_ON_ERR) state_q <= HALT;
        HALT:    if (err_clr)                state_q <= RUN;
        default:                             state_q <= RUN;
      endcase

      if (new_err && (!err_q || err_clr)) begin
        err_q  <= 1'b1;
        code_q <= new_code;
      end else if (err_clr) begin
        err_q  <= 1'b0;
        code_q <= 4'd0;
      end
    end
  end

  assign err       = err_q;
  assign err_code  = code_q;
  assign ro_cycles = ro_cnt_q;
  assign ao_cycles = ao_cnt_q;

endmodule

// File: tb/tb_msfsm_event_decoder.sv
// Directed bench: two decoders share stimulus; dut_s halts on error,
// dut_n keeps running. Both use a 4-bit counter so wrap is reachable.
module tb_msfsm_event_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic x_PLUS = 0, x_MINUS = 0, Ro_PLUS = 0, Ro_PLUSa = 0;
  logic Ro_MINUS = 0, Ro_MINUSa = 0, Ao_PLUS = 0, Ao_MINUS = 0, err_clr = 0;

  logic x_s, Ro_s, Ao_s, err_s;
  logic [3:0] code_s, roc_s, aoc_s;
  logic x_n, Ro_n, Ao_n, err_n;
  logic [3:0] code_n, roc_n, aoc_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msfsm_event_decoder #(.CNT_W(4), .STOP_ON_ERR(1'b1)) dut_s (
    .clk(clk), .reset(reset),
    .x_PLUS(x_PLUS), .x_MINUS(x_MINUS), .Ro_PLUS(Ro_PLUS), .Ro_PLUSa(Ro_PLUSa),
    .Ro_MINUS(Ro_MINUS), .Ro_MINUSa(Ro_MINUSa), .Ao_PLUS(Ao_PLUS), .Ao_MINUS(Ao_MINUS),
    .err_clr(err_clr), .x(x_s), .Ro(Ro_s), .Ao(Ao_s), .err(err_s),
    .err_code(code_s), .ro_cycles(roc_s), .ao_cycles(aoc_s)
  );

  msfsm_event_decoder #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut_n (
    .clk(clk), .reset(reset),
    .x_PLUS(x_PLUS), .x_MINUS(x_MINUS), .Ro_PLUS(Ro_PLUS), .Ro_PLUSa(Ro_PLUSa),
    .Ro_MINUS(Ro_MINUS), .Ro_MINUSa(Ro_MINUSa), .Ao_PLUS(Ao_PLUS), .Ao_MINUS(Ao_MINUS),
    .err_clr(err_clr), .x(x_n), .Ro(Ro_n), .Ao(Ao_n), .err(err_n),
    .err_code(code_n), .ro_cycles(roc_n), .ao_cycles(aoc_n)
  );

  // Apply the currently driven inputs for one edge, then return them to idle.
  task automatic cyc();
    @(posedge clk); #1;
    x_PLUS = 0; x_MINUS = 0; Ro_PLUS = 0; Ro_PLUSa = 0;
    Ro_MINUS = 0; Ro_MINUSa = 0; Ao_PLUS = 0; Ao_MINUS = 0; err_clr = 0;
    reset = 0;
  endtask

  task automatic do_reset();
    reset = 1; cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x_s !== 1'b0)    begin failures++; $display("FAIL reset_x got=%b exp=0", x_s); end
    checks++; if (Ro_s !== 1'b0)   begin failures++; $display("FAIL reset_ro got=%b exp=0", Ro_s); end
    checks++; if (Ao_s !== 1'b0)   begin failures++; $display("FAIL reset_ao got=%b exp=0", Ao_s); end
    checks++; if (err_s !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b exp=0", err_s); end
    checks++; if (code_s !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", code_s); end
    checks++; if (roc_s !== 4'h0 || aoc_s !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", roc_s, aoc_s); end
  endtask

  task automatic test_basic();
    do_reset();
    cyc();
    Ro_PLUS = 1; cyc();
    checks++; if (Ro_s !== 1'b1)   begin failures++; $display("FAIL basic_ro_rise got=%b exp=1", Ro_s); end
    checks++; if (roc_s !== 4'd1)  begin failures++; $display("FAIL basic_ro_cnt got=%0d exp=1", roc_s); end
    cyc();
    Ro_MINUSa = 1; cyc();
    checks++; if (Ro_s !== 1'b0)   begin failures++; $display("FAIL basic_ro_fall got=%b exp=0", Ro_s); end
    checks++; if (err_s !== 1'b0)  begin failures++; $display("FAIL basic_err got=%b exp=0", err_s); end
    Ao_PLUS = 1; x_PLUS = 1; cyc();
    checks++; if (Ao_s !== 1'b1 || x_s !== 1'b1) begin failures++; $display("FAIL basic_ao_x_rise got=%b%b exp=11", Ao_s, x_s); end
    checks++; if (aoc_s !== 4'd1)  begin failures++; $display("FAIL basic_ao_cnt got=%0d exp=1", aoc_s); end
    Ao_MINUS = 1; x_MINUS = 1; cyc();
    checks++; if (Ao_s !== 1'b0 || x_s !== 1'b0 || err_s !== 1'b0) begin failures++; $display("FAIL basic_ao_x_fall got=%b%b err=%b exp=00 err=0", Ao_s, x_s, err_s); end
  endtask

  task automatic test_conflict_halt();
    do_reset();
    Ao_PLUS = 1; Ao_MINUS = 1; cyc();
    checks++; if (Ao_s !== 1'b0)   begin failures++; $display("FAIL conflict_ao got=%b exp=0", Ao_s); end
    checks++; if (err_s !== 1'b1)  begin failures++; $display("FAIL conflict_err got=%b exp=1", err_s); end
    checks++; if (code_s !== 4'b1101) begin failures++; $display("FAIL conflict_code got=%b exp=1101", code_s); end
    x_PLUS = 1; cyc();
    checks++; if (x_s !== 1'b0)    begin failures++; $display("FAIL halt_x_ignored got=%b exp=0", x_s); end
    err_clr = 1; cyc();
    checks++; if (err_s !== 1'b0 || code_s !== 4'h0) begin failures++; $display("FAIL halt_clr got err=%b code=%b exp 0/0000", err_s, code_s); end
    x_PLUS = 1; cyc();
    checks++; if (x_s !== 1'b1)    begin failures++; $display("FAIL halt_resume_x got=%b exp=1", x_s); end
  endtask

  task automatic test_dup_nostop();
    do_reset();
    Ro_PLUS = 1; Ro_PLUSa = 1; x_PLUS = 1; cyc();
    checks++; if (code_n !== 4'b1011) begin failures++; $display("FAIL dup_code_n got=%b exp=1011", code_n); end
    checks++; if (x_n !== 1'b1 || Ro_n !== 1'b0) begin failures++; $display("FAIL dup_levels_n got x=%b Ro=%b exp x=1 Ro=0", x_n, Ro_n); end
    checks++; if (roc_n !== 4'd0)  begin failures++; $display("FAIL dup_cnt_n got=%0d exp=0", roc_n); end
    checks++; if (code_s !== 4'b1011 || x_s !== 1'b1) begin failures++; $display("FAIL dup_s got code=%b x=%b exp 1011/1", code_s, x_s); end
    Ao_PLUS = 1; cyc();
    checks++; if (Ao_n !== 1'b1)   begin failures++; $display("FAIL nostop_ao got=%b exp=1", Ao_n); end
    checks++; if (err_n !== 1'b1 || code_n !== 4'b1011) begin failures++; $display("FAIL nostop_sticky got err=%b code=%b exp 1/1011", err_n, code_n); end
    checks++; if (Ao_s !== 1'b0)   begin failures++; $display("FAIL stop_ao_frozen got=%b exp=0", Ao_s); end
    // Later error in no-stop mode must not overwrite the first code.
    Ao_PLUS = 1; cyc();
    checks++; if (code_n !== 4'b1011) begin failures++; $display("FAIL nostop_first_code got=%b exp=1011", code_n); end
  endtask

  task automatic test_priority();
    do_reset();
    x_PLUS = 1; cyc();
    x_PLUS = 1; Ao_MINUS = 1; cyc();
    checks++; if (code_s !== 4'b0110) begin failures++; $display("FAIL prio_code got=%b exp=0110", code_s); end
    checks++; if (x_s !== 1'b1 || Ao_s !== 1'b0) begin failures++; $display("FAIL prio_levels got x=%b Ao=%b exp 1/0", x_s, Ao_s); end
    err_clr = 1; cyc();
    checks++; if (err_s !== 1'b0 || code_s !== 4'h0) begin failures++; $display("FAIL prio_clr got err=%b code=%b exp 0/0000", err_s, code_s); end
    Ao_PLUS = 1; cyc();
    checks++; if (Ao_s !== 1'b1 || aoc_s !== 4'd1) begin failures++; $display("FAIL prio_ao_after_clr got Ao=%b cnt=%0d exp 1/1", Ao_s, aoc_s); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      Ro_PLUS = 1; cyc();
      Ro_MINUS = 1; cyc();
      if (i == 14) begin
        checks++; if (roc_s !== 4'd15) begin failures++; $display("FAIL wrap_pre got=%0d exp=15", roc_s); end
      end
    end
    checks++; if (roc_s !== 4'd0 || err_s !== 1'b0) begin failures++; $display("FAIL wrap got cnt=%0d err=%b exp 0/0", roc_s, err_s); end
    Ro_PLUS = 1; cyc();
    Ro_MINUS = 1; cyc();
    checks++; if (roc_s !== 4'd1)  begin failures++; $display("FAIL wrap_post got=%0d exp=1", roc_s); end
    reset = 1; Ro_PLUS = 1; cyc();
    checks++; if (Ro_s !== 1'b0 || roc_s !== 4'd0) begin failures++; $display("FAIL reset_discard got Ro=%b cnt=%0d exp 0/0", Ro_s, roc_s); end
  endtask

  task automatic test_clr_vs_err();
    do_reset();
    err_clr = 1; Ro_MINUS = 1; cyc();
    checks++; if (err_s !== 1'b1 || code_s !== 4'b1010) begin failures++; $display("FAIL clr_vs_err got err=%b code=%b exp 1/1010", err_s, code_s); end
    Ro_PLUS = 1; cyc();
    checks++; if (Ro_s !== 1'b0)   begin failures++; $display("FAIL clr_vs_err_halt got Ro=%b exp 0", Ro_s); end
    checks++; if (Ro_n !== 1'b1 || code_n !== 4'b1010) begin failures++; $display("FAIL clr_vs_err_n got Ro=%b code=%b exp 1/1010", Ro_n, code_n); end
    err_clr = 1; x_PLUS = 1; cyc();
    checks++; if (x_s !== 1'b0 || err_s !== 1'b0) begin failures++; $display("FAIL clr_in_halt got x=%b err=%b exp 0/0", x_s, err_s); end
    x_PLUS = 1; cyc();
    checks++; if (x_s !== 1'b1)    begin failures++; $display("FAIL clr_resume got x=%b exp 1", x_s); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_conflict_halt();
    test_dup_nostop();
    test_priority();
    test_wrap();
    test_clr_vs_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
